instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of decode; sole driver of the combinational instruction ROM address.
- Holds the program counter and presents the PC to the ROM each cycle.
- Captures the returned 32-bit word into a small prefetch FIFO.
- Hands {pc, instruction} pairs to decode over a valid/ready handshake; handles branch redirects and out-of-range/misaligned fetch faults.

---
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage: PC, ROM addressing, prefetch FIFO, branch
//                redirect and sticky misaligned/out-of-range fetch fault.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          MEM_SIZE   = 4096,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fetch_fault
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam int          CW          = AW + 1;
    localparam logic [CW-1:0] c_DEPTH   = CW'(FIFO_DEPTH);
    localparam logic [64:0] c_MEM_LIMIT = 65'(MEM_SIZE);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t          r_state;
    logic [63:0]     r_pc;
    logic            r_fault;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [63:0]     r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]     r_fifo_instr [FIFO_DEPTH];
    logic [63:0]     r_out_pc;
    logic [31:0]     r_out_instr;

    logic            w_deq;
    logic            w_enq;
    logic            w_pc_bad;
    logic [CW-1:0]   w_remain;
    logic [AW-1:0]   w_next_head;

    // 65-bit sum so addresses near 2^64 cannot wrap into range.
    function automatic logic addr_bad(input logic [63:0] a);
        return (a[1:0] != 2'b00) || (({1'b0, a} + 65'd3) >= c_MEM_LIMIT);
    endfunction

    assign out_valid   = (r_count != '0);
    assign w_deq       = out_valid && out_ready;
    assign w_pc_bad    = addr_bad(r_pc);
    assign w_enq       = (r_state == S_RUN) && !br_taken && !w_pc_bad &&
                         ((r_count < c_DEPTH) || w_deq);
    assign w_remain    = r_count - CW'(w_deq);
    assign w_next_head = r_head + AW'(w_deq);

    assign imem_addr   = r_pc;
    assign out_pc      = r_out_pc;
    assign out_instr   = r_out_instr;
    assign fetch_fault = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_fault     <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
        end else if (br_taken) begin
            // Any head transfer this cycle has already happened; the rest is flushed.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_pc    <= br_target;
            if (addr_bad(br_target)) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
            end else begin
                r_state <= S_RUN;
                r_fault <= 1'b0;
            end
        end else begin
            if (w_enq) begin
                r_fifo_pc[r_tail]    <= r_pc;
                r_fifo_instr[r_tail] <= imem_instr;
                r_tail               <= r_tail + AW'(1);
                r_pc                 <= r_pc + 64'd4;
            end
            r_head  <= w_next_head;
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            if ((r_state == S_RUN) && w_pc_bad) begin
                r_state <= S_FAULT;
                r_fault <= 1'b1;
            end
            // Output registers mirror next cycle's head; they hold when the FIFO runs dry.
            if (w_remain != '0) begin
                r_out_pc    <= r_fifo_pc[w_next_head];
                r_out_instr <= r_fifo_instr[w_next_head];
            end else if (w_enq) begin
                r_out_pc    <= r_pc;
                r_out_instr <= imem_instr;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam logic [63:0] RESET_PC   = 64'd0;
    localparam int          MEM_SIZE   = 4096;
    localparam int          FIFO_DEPTH = 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        br_taken;
    logic [63:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_fault;

    logic [31:0] salt = 32'd0;
    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference model state
    logic [63:0] m_pc;
    logic        m_fault;
    ent_t        m_q[$];
    ent_t        m_last;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .MEM_SIZE   (MEM_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fetch_fault (fetch_fault)
    );

    function automatic logic good_addr(input logic [63:0] a);
        return (a[1:0] == 2'b00) && (a <= 64'(MEM_SIZE - 4));
    endfunction

    function automatic logic [31:0] rom_word(input logic [63:0] a, input logic [31:0] s);
        if (good_addr(a)) return 32'(a >> 2) ^ s;
        return 32'hxxxx_xxxx;
    endfunction

    assign imem_instr = rom_word(imem_addr, salt);

    function automatic logic [161:0] expv();
        ent_t h;
        h = (m_q.size() != 0) ? m_q[0] : m_last;
        return {m_pc, (m_q.size() != 0), h.pc, h.instr, m_fault};
    endfunction

    function automatic logic [161:0] actv();
        return {imem_addr, out_valid, out_pc, out_instr, fetch_fault};
    endfunction

    // Apply one cycle of inputs, advance the model by the same edge, sample after it.
    task automatic step(input logic rst, input logic br, input logic [63:0] tgt, input logic rdy);
        logic deq;
        int   size_before;
        reset = rst; br_taken = br; br_target = tgt; out_ready = rdy;
        size_before = m_q.size();
        deq = (size_before != 0) && rdy;
        if (rst) begin
            m_q.delete();
            m_pc    = RESET_PC;
            m_fault = 1'b0;
            m_last  = '0;
        end else begin
            if (deq) void'(m_q.pop_front());
            if (br) begin
                m_q.delete();
                m_pc    = tgt;
                m_fault = !good_addr(tgt);
            end else if (!m_fault) begin
                if (!good_addr(m_pc)) begin
                    m_fault = 1'b1;
                end else if (size_before < FIFO_DEPTH || deq) begin
                    m_q.push_back('{pc: m_pc, instr: rom_word(m_pc, salt)});
                    m_pc = m_pc + 64'd4;
                end
            end
            if (m_q.size() != 0) m_last = m_q[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 64'h200, 1'b1);
        step(1'b1, 1'b1, 64'h203, 1'b0);
        n_chk++;
        if (actv() !== expv()) $display("FAIL reset_model: got %h expected %h", actv(), expv());
        else n_pass++;
        n_chk++;
        if ({out_valid, fetch_fault, out_pc, out_instr, imem_addr} !== {2'b00, 96'd0, RESET_PC})
            $display("FAIL reset_values: got v=%b f=%b pc=%h ins=%h addr=%h expected all zero/RESET_PC",
                     out_valid, fetch_fault, out_pc, out_instr, imem_addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        step(1'b1, 1'b0, 64'd0, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_chk++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 64'd0, 32'd0})
            $display("FAIL stream_first: got v=%b pc=%h ins=%h expected v=1 pc=0 ins=0",
                     out_valid, out_pc, out_instr);
        else n_pass++;
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b0, 64'd0, 1'b1);
            n_chk++;
            if (actv() !== expv() || out_pc !== 64'(4 * i) || imem_addr !== 64'(4 * i + 4))
                $display("FAIL stream_%0d: got %h expected %h", i, actv(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] seen[$];
        step(1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 64'd0, 1'b0);
            n_chk++;
            if (actv() !== expv()) $display("FAIL bp_stall_%0d: got %h expected %h", i, actv(), expv());
            else n_pass++;
        end
        n_chk++;
        if (imem_addr !== 64'd8) $display("FAIL bp_hold_addr: got %h expected 8", imem_addr);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen.push_back(out_pc);
            step(1'b0, 1'b0, 64'd0, 1'b1);
            n_chk++;
            if (actv() !== expv()) $display("FAIL bp_drain_%0d: got %h expected %h", i, actv(), expv());
            else n_pass++;
        end
        n_chk++;
        if (seen.size() != 4 || seen[0] !== 64'd0 || seen[1] !== 64'd4 || seen[2] !== 64'd8 || seen[3] !== 64'd12)
            $display("FAIL bp_order: got %0d transfers %p expected 0,4,8,12", seen.size(), seen);
        else n_pass++;
    endtask

    task automatic test_redirect();
        step(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_chk++;
        if (out_pc !== 64'd8 || !out_valid) $display("FAIL redir_setup: got v=%b pc=%h expected v=1 pc=8", out_valid, out_pc);
        else n_pass++;
        step(1'b0, 1'b1, 64'h100, 1'b1);
        n_chk++;
        if (actv() !== expv() || imem_addr !== 64'h100 || out_valid !== 1'b0)
            $display("FAIL redir_flush: got %h expected %h", actv(), expv());
        else n_pass++;
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_chk++;
        if (actv() !== expv() || out_valid !== 1'b1 || out_pc !== 64'h100)
            $display("FAIL redir_resume: got %h expected %h", actv(), expv());
        else n_pass++;
    endtask

    task automatic test_end_of_memory();
        step(1'b0, 1'b1, 64'hFF8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 64'd0, 1'b1);
            n_chk++;
            if (actv() !== expv()) $display("FAIL eom_%0d: got %h expected %h", i, actv(), expv());
            else n_pass++;
        end
        n_chk++;
        if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'h1000)
            $display("FAIL eom_fault: got f=%b v=%b addr=%h expected f=1 v=0 addr=1000",
                     fetch_fault, out_valid, imem_addr);
        else n_pass++;
        step(1'b0, 1'b1, 64'h40, 1'b1);
        n_chk++;
        if (fetch_fault !== 1'b0 || imem_addr !== 64'h40)
            $display("FAIL eom_recover: got f=%b addr=%h expected f=0 addr=40", fetch_fault, imem_addr);
        else n_pass++;
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_chk++;
        if (actv() !== expv() || out_pc !== 64'h40) $display("FAIL eom_resume: got %h expected %h", actv(), expv());
        else n_pass++;
    endtask

    task automatic test_misaligned();
        step(1'b0, 1'b1, 64'h102, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (actv() !== expv() || fetch_fault !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL misalign_%0d: got %h expected %h", i, actv(), expv());
            else n_pass++;
            step(1'b0, 1'b0, 64'd0, i[0]);
        end
        step(1'b0, 1'b1, 64'h80, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_chk++;
        if (actv() !== expv() || fetch_fault !== 1'b0 || out_pc !== 64'h80)
            $display("FAIL misalign_recover: got %h expected %h", actv(), expv());
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b0, 64'd0, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        n_chk++;
        if (out_valid !== 1'b0 || imem_addr !== RESET_PC || fetch_fault !== 1'b0)
            $display("FAIL midreset: got v=%b addr=%h f=%b expected v=0 addr=%h f=0",
                     out_valid, imem_addr, fetch_fault, RESET_PC);
        else n_pass++;
        step(1'b0, 1'b0, 64'd0, 1'b1);
        n_chk++;
        if (actv() !== expv() || out_pc !== RESET_PC)
            $display("FAIL midreset_restart: got %h expected %h", actv(), expv());
        else n_pass++;
    endtask

    task automatic test_random();
        logic        br;
        logic [63:0] tgt;
        salt = $urandom;
        step(1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            br = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 64'({$urandom_range(0, 1023), 2'b00});
                1:       tgt = 64'({$urandom_range(0, 1023), 2'b00}) | 64'($urandom_range(1, 3));
                2:       tgt = 64'hFF0 + 64'({$urandom_range(0, 3), 2'b00});
                default: tgt = 64'hFFFF_FFFF_FFFF_FFFC;
            endcase
            if (tgt == 64'hFFFF_FFFF_FFFF_FFFC && $urandom_range(0, 1) == 0) tgt = 64'h10;
            step(($urandom_range(0, 63) == 0), br, tgt, ($urandom_range(0, 9) < 7));
            n_chk++;
            if (actv() !== expv()) $display("FAIL random_%0d: got %h expected %h", i, actv(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; br_taken = 1'b0; br_target = '0; out_ready = 1'b0;
        m_pc = RESET_PC; m_fault = 1'b0; m_last = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_end_of_memory();
        test_misaligned();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
